// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU share arbiter.
package alu_arb_pkg;

  localparam int unsigned ALU_DW = 32;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } alu_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = IDW'((int'(ptr) + k) % int'(NREQ));
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters, one transaction at a time, round-robin.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = ALU_DW,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0] req_operand1,
  input  logic [NREQ*DW-1:0] req_operand2,
  input  logic [NREQ*2-1:0] req_alu_control,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DW-1:0]     rsp_result,
  output logic [DW-1:0]     alu_operand1,
  output logic [DW-1:0]     alu_operand2,
  output logic [1:0]        alu_control,
  input  logic [DW-1:0]     alu_result,
  output logic              busy
);

  alu_arb_state_e state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [DW-1:0]  rsp_result_q, rsp_result_d;
  logic [DW-1:0]  op1_q, op1_d;
  logic [DW-1:0]  op2_q, op2_d;
  logic [1:0]     ctrl_q, ctrl_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Grant in IDLE doubles as the handshake; rst_n gating keeps req_ready low while in reset.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_id_d     = gnt_id_q;
    rsp_result_d = rsp_result_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    ctrl_d       = ctrl_q;
    req_ready    = '0;
    rsp_valid    = '0;
    busy         = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (rst_n) begin
          req_ready = arb_gnt;
          if (|arb_gnt) begin
            op1_d    = req_operand1[int'(arb_idx)*int'(DW) +: DW];
            op2_d    = req_operand2[int'(arb_idx)*int'(DW) +: DW];
            ctrl_d   = req_alu_control[int'(arb_idx)*2 +: 2];
            gnt_id_d = arb_idx;
            rr_ptr_d = IDW'((int'(arb_idx) + 1) % int'(NREQ));
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid[gnt_id_q] = 1'b1;
        if (rsp_ready[gnt_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_id_q     <= '0;
      rsp_result_q <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= ALU_ADD;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_id_q     <= gnt_id_d;
      rsp_result_q <= rsp_result_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign rsp_result   = rsp_result_q;
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_control  = ctrl_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one CortexM0 ALU instance between `NREQ` requesters (e.g. the execute stage, the address generator and the debug port) using round-robin arbitration and valid/ready handshakes. It is one transaction at a time: grant, register operands into the ALU, capture the result, return it to the granted requester. It sits between the requesters and the combinational ALU, and drives the ALU's operand and control inputs directly.

## Interface
- `NREQ`, default 3: number of requesters (2..8).
- `DW`, default 32: operand/result width; must match the ALU.
- `IDW`, default `$clog2(NREQ)`: requester-index width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NREQ`: per-requester request valid.
- `req_ready` out `NREQ`: per-requester accept; at most one bit high.
- `req_operand1` in `NREQ*DW`: packed operand 1; requester i in slice `[i*DW +: DW]`.
- `req_operand2` in `NREQ*DW`: packed operand 2, same packing.
- `req_alu_control` in `NREQ*2`: packed op code (00 ADD, 01 SUB, others pass through).
- `rsp_valid` out `NREQ`: one-hot response valid, bit = granted requester.
- `rsp_ready` in `NREQ`: per-requester response accept.
- `rsp_result` out `DW`: result of the current response.
- `alu_operand1` out `DW`: registered operand 1 driving the ALU.
- `alu_operand2` out `DW`: registered operand 2 driving the ALU.
- `alu_control` out 2: registered op code driving the ALU.
- `alu_result` in `DW`: combinational result from the ALU.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready` is the combinational one-hot round-robin grant over `req_valid`.
  - The search starts at `rr_ptr` and wraps modulo `NREQ`.
  - If no request is valid, `req_ready` is 0 and the FSM stays in IDLE.
  - Any grant is a handshake. On that edge:
    - latch the granted slices into `alu_operand1`, `alu_operand2` and `alu_control`;
    - latch the grant index into `gnt_id`;
    - set `rr_ptr` to (`gnt_id` + 1) mod `NREQ`;
    - go to EXEC.
- **EXEC** (1 cycle)
  - `req_ready` is 0.
  - On the edge, `rsp_result` <= `alu_result` and the FSM goes to RESP.
- **RESP**
  - `rsp_valid[gnt_id]` is 1 and all other bits are 0.
  - `rsp_result` is held stable until `rsp_ready[gnt_id]` is 1.
  - On that edge, go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- ALU outputs hold their last values outside grant edges, so the ALU does not toggle when idle.
- A requester may drop `req_valid` while not granted. There is no penalty and the pointer is unchanged.
- Codes 10 and 11 are forwarded unchanged to the ALU. The returned result (0 from the ALU) is delivered normally; there is no error flag.
- Width rules:
  - Arithmetic is modulo 2^`DW`; carry and borrow are discarded by the ALU.
  - The arbiter never alters data.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `gnt_id` 0;
  - `req_ready` 0, `rsp_valid` 0, `rsp_result` 0;
  - `alu_operand1` 0, `alu_operand2` 0, `alu_control` 2'b00, `busy` 0.
- Latency:
  - Grant edge at T; result registered at T+1.
  - `rsp_valid` high during cycle T+2 (between edges T+1 and T+2).
  - The earliest next grant is the cycle after the response handshake.
  - Minimum 3 cycles per transaction.
- `req_ready` depends combinationally on `req_valid`. Requesters must not derive `req_valid` from `req_ready`.
- Simultaneous requests: the lowest index at or after `rr_ptr` (cyclically) wins. No requester waits more than `NREQ`-1 grants while it is asserted.
- A new request arriving while the FSM is busy waits; it is not queued internally.
- If `rsp_ready` is held low, RESP is held indefinitely with `rsp_result` stable.
- Reset asserted mid-transaction:
  - the transaction is discarded and no response is issued;
  - all outputs take their reset values immediately (asynchronous).
- Reset deassertion must be synchronised externally to `clk`.

## Structure
- Package `alu_arb_pkg` holds:
  - the state enum `alu_arb_state_e` (IDLE, EXEC, RESP);
  - constants `ALU_ADD` = 2'b00 and `ALU_SUB` = 2'b01;
  - default `ALU_DW` = 32.
- Sub-module `rr_arbiter` (parameter `NREQ`):
  - inputs: `req`, `ptr`;
  - outputs: one-hot `gnt` and `gnt_idx`;
  - purely combinational;
  - reusable by other shared resources.
- The top level holds the FSM, `rr_ptr`, `gnt_id` and the operand/result registers. The ALU is instantiated outside the arbiter.

## Test plan
- **Single ADD:** `NREQ`=3; req0 sends 5 and 3 with code 00.
  - `req_ready[0]` is 1 that cycle.
  - Two cycles later, `rsp_valid` = 001 and `rsp_result` = 8.
- **SUB wrap:** req1 sends 0 and 1 with code 01 → `rsp_result` = 32'hFFFFFFFF on `rsp_valid[1]`.
- **Round-robin:** all three requesters hold `req_valid` continuously with `rsp_ready` = 111.
  - Grant order is 0, 1, 2, 0.
  - One grant per 3 cycles.
- **Backpressure:** `rsp_ready[2]` is held at 0 for 10 cycles.
  - `rsp_valid[2]` and `rsp_result` stay stable.
  - `req_ready` is 000 throughout.
  - The next grant comes 1 cycle after the handshake.
- **Reset mid-operation:** `rst_n` pulsed low during EXEC.
  - All outputs go to 0 at once, with `alu_control` = 00.
  - No `rsp_valid` afterwards.
  - `rr_ptr` returns to 0, so the first grant goes to req0 when all are valid.
- **Illegal op:** code 11 with 7 and 9 → `rsp_result` = 0; the FSM returns to IDLE normally.
